bnn_vote_accumulator: RTL and testbench



---
 rtl/bnn_vote_accumulator.sv | 152 +++++++++++++++
 tb/tb_bnn_vote_accumulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bnn_vote_accumulator.sv
// bnn_vote_accumulator
// Collects per-neuron firing votes from the BNN layer over a window of WIN_LEN
// samples. It then finds the neuron with the most votes and presents it as one
// classification result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to open a window (honoured only in IDLE)
//   in_valid   in_act carries a sample
//   in_act     NUM_NEURONS-bit activation vector
//   in_ready   a sample is accepted on an edge with in_valid & in_ready
//   busy       window in progress (ACCUM or ARGMAX)
//   out_valid  result available (HOLD)
//   out_ready  consumer takes the result
//   out_class  winning neuron index (lowest index wins ties)
//   out_count  vote count of the winner
//   out_tie    another neuron reached the winner's count
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; last result stays on out_* pins
// ACCUM   | accepting samples, one vote per set bit per neuron
// ARGMAX  | scanning the counters, one neuron per cycle
// HOLD    | result presented, waiting for out_ready
module bnn_vote_accumulator #(
  parameter int NUM_NEURONS = 4,
  parameter int CLS_W       = 2,
  parameter int CNT_W       = 4,
  parameter int WIN_LEN     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [NUM_NEURONS-1:0] in_act,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       out_class,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_tie
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] ARGMAX = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WIN_LEN - 1);
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_NEURONS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] vote_cnt [NUM_NEURONS];
  logic [CNT_W-1:0] sample_cnt;
  logic [CLS_W-1:0] scan_k;
  logic [CNT_W-1:0] best;
  logic [CLS_W-1:0] best_idx;
  logic             best_tie;

  logic [CNT_W-1:0] cand;
  logic [CNT_W-1:0] next_best;
  logic [CLS_W-1:0] next_idx;
  logic             next_tie;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state == ACCUM) || (state == ARGMAX);
  assign out_valid = (state == HOLD);

  // One comparison step of the scan. A strictly greater count is needed to
  // take over, so the lowest index keeps the win on equal counts.
  always_comb begin
    cand      = vote_cnt[scan_k];
    next_best = best;
    next_idx  = best_idx;
    next_tie  = best_tie;
    if (cand > best) begin
      next_best = cand;
      next_idx  = scan_k;
      next_tie  = 1'b0;
    end else if (cand == best) begin
      next_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      scan_k     <= '0;
      best       <= '0;
      best_idx   <= '0;
      best_tie   <= 1'b0;
      out_class  <= '0;
      out_count  <= '0;
      out_tie    <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) vote_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) vote_cnt[i] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              if (vote_cnt[i] != CNT_MAX)
                vote_cnt[i] <= vote_cnt[i] + CNT_W'(in_act[i]);
            end
            if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_SMP) begin
              state  <= ARGMAX;
              scan_k <= '0;
            end
          end
        end
        ARGMAX: begin
          // Index 0 seeds the running best. The result therefore lands
          // NUM_NEURONS edges after the last accepted sample.
          if (scan_k == '0) begin
            best     <= vote_cnt[0];
            best_idx <= '0;
            best_tie <= 1'b0;
            scan_k   <= CLS_W'(1);
          end else begin
            best     <= next_best;
            best_idx <= next_idx;
            best_tie <= next_tie;
            if (scan_k == LAST_IDX) begin
              state     <= HOLD;
              out_class <= next_idx;
              out_count <= next_best;
              out_tie   <= next_tie;
            end else begin
              scan_k <= scan_k + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Directed bench for bnn_vote_accumulator with hand-computed expectations.
module tb_bnn_vote_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] in_act;
  logic       in_ready;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_class;
  logic [3:0] out_count;
  logic       out_tie;

  int total = 0;
  int bad   = 0;

  bnn_vote_accumulator #(
    .NUM_NEURONS(4), .CLS_W(2), .CNT_W(4), .WIN_LEN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_act(in_act), .in_ready(in_ready),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_count(out_count), .out_tie(out_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_win();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feeds n back-to-back samples; each waits (bounded) for in_ready.
  task automatic feed(input logic [3:0] act, input int n);
    for (int s = 0; s < n; s++) begin
      int w;
      in_valid = 1'b1;
      in_act   = act;
      w = 0;
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("out_valid_arrives", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [1:0] cls,
                            input logic [3:0] cnt, input logic tie);
    chk({tag, "_class"}, {30'd0, out_class}, {30'd0, cls});
    chk({tag, "_count"}, {28'd0, out_count}, {28'd0, cnt});
    chk({tag, "_tie"},   {31'd0, out_tie},   {31'd0, tie});
  endtask

  initial begin
    int lat;
    int accepts;
    logic busy_ok;
    logic hold_ok;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_act = 4'h0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk_result("rst", 2'd0, 4'd0, 1'b0);

    // Clear winner: neuron 0 gets 5 votes, neuron 2 gets 3.
    start_win();
    chk("win1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("win1_busy",     {31'd0, busy},     32'd1);
    feed(4'b0001, 5);
    in_valid = 1'b1;
    feed(4'b0100, 3);
    wait_out(lat);
    chk("win1_latency", lat, 32'd4);
    chk_result("win1", 2'd0, 4'd5, 1'b0);
    take_out();
    chk("win1_released", {31'd0, out_valid}, 32'd0);
    chk("win1_idle_busy", {31'd0, busy}, 32'd0);
    chk("win1_result_kept", {28'd0, out_count}, 32'd5);

    // Four-way tie with in_valid toggling every other cycle.
    start_win();
    accepts = 0;
    busy_ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c % 2 == 0);
      in_act   = (accepts < 4) ? 4'b0011 : 4'b1100;
      if (in_valid && in_ready) accepts++;
      if (!busy) busy_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("tie_accepts", accepts, 32'd8);
    chk("tie_busy_throughout", {31'd0, busy_ok}, 32'd1);
    wait_out(lat);
    chk_result("tie", 2'd0, 4'd4, 1'b1);
    take_out();

    // Later winner, held under backpressure with ignored start pulses.
    start_win();
    feed(4'b1000, 8);
    wait_out(lat);
    chk_result("late", 2'd3, 4'd8, 1'b0);
    hold_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start = (c % 3 == 0);
      tick();
      if (!out_valid || out_class !== 2'd3 || out_count !== 4'd8) hold_ok = 1'b0;
    end
    start = 1'b0;
    chk("late_hold_stable", {31'd0, hold_ok}, 32'd1);
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("late_start_on_handshake_ignored", {31'd0, busy}, 32'd0);
    chk("late_released", {31'd0, out_valid}, 32'd0);

    // A fresh window must begin from cleared counters (no leftover neuron 3 votes).
    start_win();
    feed(4'b0100, 8);
    wait_out(lat);
    chk_result("fresh", 2'd2, 4'd8, 1'b0);
    take_out();

    // Reset in the middle of a window.
    start_win();
    feed(4'b1111, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk_result("mid_rst", 2'd0, 4'd0, 1'b0);
    start_win();
    feed(4'b0010, 8);
    wait_out(lat);
    chk_result("after_rst", 2'd1, 4'd8, 1'b0);
    take_out();

    // Samples offered while IDLE are not taken.
    in_valid = 1'b1;
    in_act   = 4'b1111;
    hold_ok  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (in_ready) hold_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("idle_not_ready", {31'd0, hold_ok}, 32'd1);
    start_win();
    feed(4'b0001, 8);
    wait_out(lat);
    chk_result("idle_in", 2'd0, 4'd8, 1'b0);
    take_out();

    // All-zero window.
    start_win();
    feed(4'b0000, 8);
    wait_out(lat);
    chk_result("zero", 2'd0, 4'd0, 1'b1);
    take_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
